// File: rtl/otter_mmio_hub.sv
// -----------------------------------------------------------------------------
// otter_mmio_hub
//
// Memory-mapped I/O hub between the OTTER_MCU IOBUS and the board peripherals.
// Address map (region byte in ADDR[31:24], slot in ADDR[23:18], ADDR[17:0]==0):
//   slots 0..NUM_IN-1                 synchronised input ports (read-only)
//   slots NUM_IN..NUM_IN+NUM_OUT-1    output registers (read/write)
//   next four slots                   PEND (W1C), MASK, TXD (push), TXS (status)
// TXS layout: bit0 empty, bit1 full, bit2 overflow (write 1 to clear),
//             bits[15:8] FIFO count.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   IOBUS_ADDR/OUT/WR MCU address, write data and one-cycle write strobe
//   IOBUS_IN          combinational read data back to the MCU
//   IN_PORTS          asynchronous board inputs, port i = [i*IN_W +: IN_W]
//   OUT_PORTS         output registers, reg j = [j*OUT_W +: OUT_W]
//   INTR              registered interrupt request (any pending & mask)
//   TX_DATA/VALID     first-word-fall-through head of the transmit FIFO
//   TX_READY          consumer accepts the head when TX_VALID && TX_READY
// -----------------------------------------------------------------------------
module otter_mmio_hub #(
   parameter int          NUM_IN      = 2,
   parameter int          NUM_OUT     = 2,
   parameter int          IN_W        = 16,
   parameter int          OUT_W       = 16,
   parameter int          SYNC_STAGES = 2,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          TX_W        = 8,
   parameter logic [7:0]  REGION      = 8'h11
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [31:0]               IOBUS_ADDR,
   input  logic [31:0]               IOBUS_OUT,
   input  logic                      IOBUS_WR,
   output logic [31:0]               IOBUS_IN,
   input  logic [NUM_IN*IN_W-1:0]    IN_PORTS,
   output logic [NUM_OUT*OUT_W-1:0]  OUT_PORTS,
   output logic                      INTR,
   output logic [TX_W-1:0]           TX_DATA,
   output logic                      TX_VALID,
   input  logic                      TX_READY
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [5:0] S_PEND = 6'(NUM_IN + NUM_OUT);
   localparam logic [5:0] S_MASK = 6'(NUM_IN + NUM_OUT + 1);
   localparam logic [5:0] S_TXD  = 6'(NUM_IN + NUM_OUT + 2);
   localparam logic [5:0] S_TXS  = 6'(NUM_IN + NUM_OUT + 3);

   // ---------------------------------------------------------------- decode
   logic       hit;
   logic [5:0] slot;
   logic       wr_hit;

   assign hit    = (IOBUS_ADDR[31:24] == REGION) && (IOBUS_ADDR[17:0] == 18'h0);
   assign slot   = IOBUS_ADDR[23:18];
   assign wr_hit = IOBUS_WR && hit;

   // ------------------------------------------------------------ state
   logic [IN_W-1:0]   sync_q [NUM_IN][SYNC_STAGES];
   logic [IN_W-1:0]   sync_d [NUM_IN][SYNC_STAGES];
   logic [IN_W-1:0]   prev_q [NUM_IN];
   logic [IN_W-1:0]   prev_d [NUM_IN];
   logic [NUM_IN-1:0] change;
   logic [NUM_IN-1:0] pending_q, pending_d;
   logic [NUM_IN-1:0] mask_q, mask_d;
   logic              intr_q, intr_d;
   logic [OUT_W-1:0]  out_q [NUM_OUT];
   logic [OUT_W-1:0]  out_d [NUM_OUT];

   logic [TX_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              fifo_empty, fifo_full;
   logic              push, pop, push_ok;

   // --------------------------------------------- inputs and interrupts
   always_comb begin
      // NOTE: every variable gets a default before any conditional update so
      // no path leaves it unassigned and no latch is inferred.
      change = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         sync_d[i][0] = IN_PORTS[i*IN_W +: IN_W];
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[i][s] = sync_q[i][s-1];
         end
         prev_d[i] = sync_q[i][SYNC_STAGES-1];
         change[i] = (sync_q[i][SYNC_STAGES-1] != prev_q[i]);
      end

      // Clear first, then set: a fresh change wins over a same-cycle W1C.
      pending_d = pending_q;
      if (wr_hit && slot == S_PEND) begin
         pending_d = pending_d & ~IOBUS_OUT[NUM_IN-1:0];
      end
      pending_d = pending_d | change;

      mask_d = mask_q;
      if (wr_hit && slot == S_MASK) begin
         mask_d = IOBUS_OUT[NUM_IN-1:0];
      end

      intr_d = |(pending_q & mask_q);

      for (int j = 0; j < NUM_OUT; j++) begin
         out_d[j] = out_q[j];
         if (wr_hit && slot == 6'(NUM_IN + j)) begin
            out_d[j] = IOBUS_OUT[OUT_W-1:0];
         end
      end
   end

   // ------------------------------------------------------------ TX FIFO
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && TX_READY;
   assign push       = wr_hit && (slot == S_TXD);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok    = push && (!fifo_full || pop);

   always_comb begin
      rptr_d     = pop     ? rptr_q + PTR_W'(1) : rptr_q;
      wptr_d     = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      overflow_d = overflow_q;
      if (wr_hit && slot == S_TXS && IOBUS_OUT[2]) begin
         overflow_d = 1'b0;
      end
      if (push && fifo_full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   // NOTE: the storage array has no reset; TX_DATA is gated to 0 while the
   // FIFO is empty, so stale entries are never observable.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_q[wptr_q] <= IOBUS_OUT[TX_W-1:0];
      end
   end

   // ---------------------------------------------------- state registers
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_IN; i++) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
               sync_q[i][s] <= '0;
            end
            prev_q[i] <= '0;
         end
         for (int j = 0; j < NUM_OUT; j++) begin
            out_q[j] <= '0;
         end
         pending_q  <= '0;
         mask_q     <= '0;
         intr_q     <= 1'b0;
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         out_q      <= out_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         intr_q     <= intr_d;
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------------------------------------------------- read mux
   always_comb begin
      IOBUS_IN = 32'h0;
      if (hit) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (slot == 6'(i)) IOBUS_IN = 32'(sync_q[i][SYNC_STAGES-1]);
         end
         for (int j = 0; j < NUM_OUT; j++) begin
            if (slot == 6'(NUM_IN + j)) IOBUS_IN = 32'(out_q[j]);
         end
         if (slot == S_PEND) IOBUS_IN = 32'(pending_q);
         if (slot == S_MASK) IOBUS_IN = 32'(mask_q);
         // The count field is 8 bits wide; a full 256-deep FIFO shows 0 there
         // and is identified by the full flag instead.
         if (slot == S_TXS) begin
            IOBUS_IN = {16'h0, 8'(count_q), 5'h0, overflow_q, fifo_full, fifo_empty};
         end
      end
   end

   // ------------------------------------------------------------ outputs
   for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      assign OUT_PORTS[j*OUT_W +: OUT_W] = out_q[j];
   end

   assign INTR     = intr_q;
   assign TX_VALID = !fifo_empty;
   assign TX_DATA  = fifo_empty ? '0 : mem_q[rptr_q];

   // Upper write-data bits are legitimately ignored by every register.
   logic unused_wdata;
   assign unused_wdata = ^IOBUS_OUT;

endmodule

// File: tb/tb_otter_mmio_hub.sv
// -----------------------------------------------------------------------------
// tb_otter_mmio_hub
//
// Self-checking bench for otter_mmio_hub at default parameters. A behavioural
// model (history of sampled pins, arrays for registers, a queue for the FIFO)
// predicts every output each cycle; directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_otter_mmio_hub;

   localparam int NI = 2;
   localparam int NO = 2;
   localparam int IW = 16;
   localparam int OW = 16;
   localparam int SS = 2;
   localparam int FD = 8;
   localparam int TW = 8;

   localparam logic [31:0] A_IN0  = 32'h1100_0000;
   localparam logic [31:0] A_OUT0 = 32'h1108_0000;
   localparam logic [31:0] A_OUT1 = 32'h110C_0000;
   localparam logic [31:0] A_PEND = 32'h1110_0000;
   localparam logic [31:0] A_MASK = 32'h1114_0000;
   localparam logic [31:0] A_TXD  = 32'h1118_0000;
   localparam logic [31:0] A_TXS  = 32'h111C_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       iobus_addr, iobus_out, iobus_in;
   logic              iobus_wr;
   logic [NI*IW-1:0]  in_ports;
   logic [NO*OW-1:0]  out_ports;
   logic              intr;
   logic [TW-1:0]     tx_data;
   logic              tx_valid, tx_ready;

   otter_mmio_hub dut (
      .CLK        (clk),
      .RST        (rst),
      .IOBUS_ADDR (iobus_addr),
      .IOBUS_OUT  (iobus_out),
      .IOBUS_WR   (iobus_wr),
      .IOBUS_IN   (iobus_in),
      .IN_PORTS   (in_ports),
      .OUT_PORTS  (out_ports),
      .INTR       (intr),
      .TX_DATA    (tx_data),
      .TX_VALID   (tx_valid),
      .TX_READY   (tx_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // ------------------------------------------------------- reference model
   logic [NI*IW-1:0] hist[$];     // pins sampled at each clock edge
   logic [OW-1:0]    out_m [NO];
   logic [NI-1:0]    pend_m, mask_m;
   logic             intr_m, ovf_m;
   logic [TW-1:0]    fifo_m[$];
   logic             rdy_v;
   logic [NI*IW-1:0] pins_v;

   task automatic model_reset();
      for (int j = 0; j < NO; j++) out_m[j] = '0;
      pend_m = '0; mask_m = '0; intr_m = 1'b0; ovf_m = 1'b0;
      fifo_m.delete();
      hist.delete();
      for (int k = 0; k <= SS; k++) hist.push_back('0);
   endtask

   // A pin level sampled at edge n is readable after edge n+SS-1.
   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [NI*IW-1:0] cur;
      int slot;
      cur  = hist[hist.size()-SS];
      slot = int'(a[23:18]);
      if (a[31:24] != 8'h11 || a[17:0] != 18'h0) return 32'h0;
      if (slot < NI) return 32'(cur[slot*IW +: IW]);
      if (slot < NI + NO) return 32'(out_m[slot-NI]);
      if (slot == NI + NO) return 32'(pend_m);
      if (slot == NI + NO + 1) return 32'(mask_m);
      if (slot == NI + NO + 3)
         return (32'(fifo_m.size()) << 8) | (32'(ovf_m) << 2)
              | (32'(fifo_m.size() == FD) << 1) | 32'(fifo_m.size() == 0);
      return 32'h0;
   endfunction

   // Apply the effect of one clock edge given the currently driven inputs.
   task automatic model_edge();
      logic [NI*IW-1:0] cur, prv;
      logic [NI-1:0]    chg;
      logic             wr, pop, push, new_intr;
      int               slot;
      cur  = hist[hist.size()-SS];
      prv  = hist[hist.size()-SS-1];
      slot = int'(iobus_addr[23:18]);
      wr   = iobus_wr && iobus_addr[31:24] == 8'h11 && iobus_addr[17:0] == 18'h0;
      pop  = (fifo_m.size() != 0) && tx_ready;
      push = wr && slot == NI + NO + 2;
      new_intr = |(pend_m & mask_m);
      for (int i = 0; i < NI; i++) chg[i] = (cur[i*IW +: IW] != prv[i*IW +: IW]);
      if (wr && slot >= NI && slot < NI + NO) out_m[slot-NI] = iobus_out[OW-1:0];
      if (wr && slot == NI + NO) pend_m = pend_m & ~iobus_out[NI-1:0];
      pend_m = pend_m | chg;
      if (wr && slot == NI + NO + 1) mask_m = iobus_out[NI-1:0];
      if (wr && slot == NI + NO + 3 && iobus_out[2]) ovf_m = 1'b0;
      if (push && fifo_m.size() == FD && !pop) ovf_m = 1'b1;
      if (pop) void'(fifo_m.pop_front());
      if (push && fifo_m.size() < FD) fifo_m.push_back(iobus_out[TW-1:0]);
      intr_m = new_intr;
   endtask

   task automatic compare_all();
      logic [NO*OW-1:0] e;
      for (int j = 0; j < NO; j++) e[j*OW +: OW] = out_m[j];
      check("out_ports", out_ports, e);
      check("intr", intr, intr_m);
      check("tx_valid", tx_valid, fifo_m.size() != 0);
      check("tx_data", tx_data, (fifo_m.size() != 0) ? fifo_m[0] : '0);
      check("iobus_in", iobus_in, model_read(iobus_addr));
   endtask

   // One bus cycle: drive at the falling edge, compare, advance one edge.
   task automatic cycle(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic chk_en, input string tag, input logic [31:0] exp);
      iobus_wr = wr; iobus_addr = addr; iobus_out = data;
      tx_ready = rdy_v; in_ports = pins_v;
      #1;
      if (chk_en) check(tag, iobus_in, exp);
      compare_all();
      model_edge();
      @(posedge clk);
      hist.push_back(pins_v);
      if (hist.size() > SS + 2) void'(hist.pop_front());
      @(negedge clk);
   endtask

   task automatic step(input logic wr, input logic [31:0] addr, input logic [31:0] data);
      cycle(wr, addr, data, 1'b0, "", 32'h0);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      cycle(1'b0, addr, 32'h0, 1'b1, tag, exp);
   endtask

   initial begin
      rst = 1'b1; iobus_wr = 1'b0; iobus_addr = '0; iobus_out = '0;
      rdy_v = 1'b0; pins_v = '0; tx_ready = 1'b0; in_ports = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_out_ports", out_ports, 0);
      check("rst_intr", intr, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      rst = 1'b0;
      rd("rst_txs", A_TXS, 32'h1);

      // Output registers, readback and misses.
      step(1'b1, A_OUT0, 32'hA5A5);
      step(1'b1, A_OUT1, 32'h1234);
      check("out_ports_p1", out_ports, 32'h1234_A5A5);
      rd("rd_out0", A_OUT0, 32'h0000_A5A5);
      rd("rd_out1", A_OUT1, 32'h0000_1234);
      rd("rd_unmapped", 32'h1130_0000, 32'h0);
      rd("rd_lowbits", 32'h1108_0004, 32'h0);
      step(1'b1, 32'h1208_0000, 32'hFFFF);
      step(1'b1, 32'h1108_0010, 32'hFFFF);
      check("miss_wr_ignored", out_ports, 32'h1234_A5A5);

      // Input sync latency, pending and interrupt timing.
      step(1'b1, A_PEND, 32'h3);
      step(1'b1, A_MASK, 32'h1);
      pins_v = 32'h0000_0001;
      step(1'b0, A_IN0, 32'h0);
      rd("in0_edge1", A_IN0, 32'h0);
      rd("in0_edge2", A_IN0, 32'h1);
      check("intr_edge3", intr, 0);
      rd("pend_edge3", A_PEND, 32'h1);
      check("intr_edge4", intr, 1);
      step(1'b1, A_PEND, 32'h1);
      check("intr_hold", intr, 1);
      step(1'b0, A_PEND, 32'h0);
      check("intr_cleared", intr, 0);

      // Masked port, then set beating a same-cycle W1C.
      pins_v = 32'h0002_0001;
      repeat (3) step(1'b0, A_PEND, 32'h0);
      rd("pend_masked", A_PEND, 32'h2);
      check("intr_masked", intr, 0);
      pins_v = 32'h0000_0001;
      step(1'b0, A_PEND, 32'h0);
      step(1'b1, A_PEND, 32'h2);
      step(1'b1, A_PEND, 32'h2);
      rd("pend_set_wins", A_PEND, 32'h2);

      // FIFO fill, overflow, in-order drain, overflow clear.
      rdy_v = 1'b0;
      for (int i = 1; i <= 9; i++) step(1'b1, A_TXD, 32'(i));
      rd("txs_full_ovf", A_TXS, 32'h0806);
      check("head_first", tx_data, 8'h01);
      rdy_v = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("drain_order", tx_data, 8'(i));
         step(1'b0, A_TXS, 32'h0);
      end
      check("drained_valid", tx_valid, 0);
      rd("txs_empty_ovf", A_TXS, 32'h0005);
      step(1'b1, A_TXS, 32'h4);
      rd("txs_ovf_clr", A_TXS, 32'h0001);

      // Push into a full FIFO while the head leaves.
      rdy_v = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1, A_TXD, 32'h10 + 32'(i));
      rd("txs_full", A_TXS, 32'h0802);
      rdy_v = 1'b1;
      step(1'b1, A_TXD, 32'h99);
      rdy_v = 1'b0;
      check("pp_head", tx_data, 8'h11);
      rd("txs_pushpop", A_TXS, 32'h0802);
      rdy_v = 1'b1;
      repeat (8) step(1'b0, A_TXS, 32'h0);

      // Randomised traffic across every slot plus misses.
      for (int n = 0; n < 600; n++) begin
         logic [5:0]  s;
         logic [31:0] a;
         s = 6'($urandom_range(0, 11));
         if (s == 6'd10) a = 32'h1108_0100;
         else if (s == 6'd11) a = 32'h2208_0000;
         else a = {8'h11, s, 18'h0};
         rdy_v = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) pins_v = NI*IW'($urandom);
         step(1'($urandom_range(0, 1)), a, $urandom);
      end

      // Asynchronous reset in the middle of a drain.
      rdy_v = 1'b1;
      repeat (10) step(1'b0, A_TXS, 32'h0);
      rdy_v = 1'b0;
      step(1'b1, A_OUT0, 32'h55);
      step(1'b1, A_PEND, 32'h3);
      step(1'b1, A_MASK, 32'h3);
      pins_v = pins_v ^ 32'h1;
      repeat (4) step(1'b0, A_PEND, 32'h0);
      step(1'b1, A_TXD, 32'hA1);
      step(1'b1, A_TXD, 32'hA2);
      step(1'b1, A_TXD, 32'hA3);
      rdy_v = 1'b1;
      step(1'b0, A_TXS, 32'h0);
      check("pre_rst_valid", tx_valid, 1);
      check("pre_rst_intr", intr, 1);
      check("pre_rst_out0", out_ports[15:0], 16'h0055);
      #2 rst = 1'b1;
      #1;
      check("async_tx_valid", tx_valid, 0);
      check("async_intr", intr, 0);
      check("async_out_ports", out_ports, 0);
      check("async_tx_data", tx_data, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rdy_v = 1'b0;
      model_reset();
      rd("post_rst_txs", A_TXS, 32'h1);
      repeat (5) step(1'b0, A_PEND, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
